// File: rtl/pipe_loopback_phy_if.sv
// PIPE bundle between the controller (master) and the loopback PHY model (slave).
// lane_present rides along with the bus as a bench-side far-end configuration input.
interface pipe_loopback_phy_if #(
   parameter int LANESNUMBER  = 16,
   parameter int MAXPIPEWIDTH = 32
);
   localparam int KW = MAXPIPEWIDTH / 8;

   logic [MAXPIPEWIDTH*LANESNUMBER-1:0] TxData;
   logic [KW*LANESNUMBER-1:0]           TxDataK;
   logic [LANESNUMBER-1:0]              TxDataValid;
   logic [LANESNUMBER-1:0]              TxElecIdle;
   logic [LANESNUMBER-1:0]              TxDetectRx_Loopback;
   logic [4*LANESNUMBER-1:0]            PowerDown;
   logic [3:0]                          Rate;
   logic [LANESNUMBER-1:0]              lane_present;

   logic [MAXPIPEWIDTH*LANESNUMBER-1:0] RxData;
   logic [KW*LANESNUMBER-1:0]           RxDataK;
   logic [LANESNUMBER-1:0]              RxDataValid;
   logic [LANESNUMBER-1:0]              RxValid;
   logic [LANESNUMBER-1:0]              RxElectricalIdle;
   logic [3*LANESNUMBER-1:0]            RxStatus;
   logic [LANESNUMBER-1:0]              PhyStatus;

   modport master (
      output TxData, TxDataK, TxDataValid, TxElecIdle, TxDetectRx_Loopback,
             PowerDown, Rate, lane_present,
      input  RxData, RxDataK, RxDataValid, RxValid, RxElectricalIdle,
             RxStatus, PhyStatus
   );

   modport slave (
      input  TxData, TxDataK, TxDataValid, TxElecIdle, TxDetectRx_Loopback,
             PowerDown, Rate, lane_present,
      output RxData, RxDataK, RxDataValid, RxValid, RxElectricalIdle,
             RxStatus, PhyStatus
   );
endinterface

// File: rtl/pipe_loopback_phy.sv
// PIPE PHY loopback responder: per-lane delayed Tx->Rx loop with skew and far-end presence,
// plus one shared control FSM answering reset, receiver detect, rate and power-state changes.
module pipe_loopback_phy #(
   parameter int LANESNUMBER    = 16,
   parameter int MAXPIPEWIDTH   = 32,
   parameter int BASE_LATENCY   = 2,
   parameter int SKEW_STEP      = 0,
   parameter int MAX_SKEW       = 3,
   parameter int RESET_LATENCY  = 4,
   parameter int DETECT_LATENCY = 8,
   parameter int RATE_LATENCY   = 16,
   parameter int PD_LATENCY     = 4
) (
   input  logic               CLK,
   input  logic               reset,
   pipe_loopback_phy_if.slave pipe
);
   localparam int W  = MAXPIPEWIDTH;
   localparam int KW = MAXPIPEWIDTH / 8;

   localparam int LAT_A   = (RESET_LATENCY > DETECT_LATENCY) ? RESET_LATENCY : DETECT_LATENCY;
   localparam int LAT_B   = (RATE_LATENCY > PD_LATENCY) ? RATE_LATENCY : PD_LATENCY;
   localparam int MAX_LAT = (LAT_A > LAT_B) ? LAT_A : LAT_B;
   localparam int CW      = $clog2(MAX_LAT) + 1;

   localparam logic [CW-1:0] RST_LAST  = CW'(RESET_LATENCY - 1);
   localparam logic [CW-1:0] DET_LAST  = CW'(DETECT_LATENCY - 1);
   localparam logic [CW-1:0] RATE_LAST = CW'(RATE_LATENCY - 1);
   localparam logic [CW-1:0] PD_LAST   = CW'(PD_LATENCY - 1);
   localparam logic [3:0]    PD_P1     = 4'd2;

   typedef enum logic [2:0] {
      RST_WAIT,
      IDLE,
      DETECT,
      RATE,
      PWR,
      RELEASE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    last_rate_q, last_rate_d;
   logic [3:0]    last_pd_q, last_pd_d;
   logic [3:0]    rate_prev_q, rate_prev_d;
   logic [3:0]    pd_prev_q, pd_prev_d;
   logic          rate_pend_q, rate_pend_d;
   logic          pd_pend_q, pd_pend_d;

   logic [3:0] pd_cur;
   logic       det_req;
   logic       op_done;
   logic       det_done;

   logic [W*LANESNUMBER-1:0]  rx_data;
   logic [KW*LANESNUMBER-1:0] rx_datak;
   logic [LANESNUMBER-1:0]    rx_datavalid;
   logic [LANESNUMBER-1:0]    rx_valid;
   logic [LANESNUMBER-1:0]    rx_eidle;
   logic [3*LANESNUMBER-1:0]  rx_status;

   assign pd_cur  = pipe.PowerDown[3:0];
   assign det_req = |pipe.TxDetectRx_Loopback;

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q     <= RST_WAIT;
         cnt_q       <= '0;
         last_rate_q <= 4'd0;
         last_pd_q   <= PD_P1;
         rate_prev_q <= 4'd0;
         pd_prev_q   <= PD_P1;
         rate_pend_q <= 1'b0;
         pd_pend_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_rate_q <= last_rate_d;
         last_pd_q   <= last_pd_d;
         rate_prev_q <= rate_prev_d;
         pd_prev_q   <= pd_prev_d;
         rate_pend_q <= rate_pend_d;
         pd_pend_q   <= pd_pend_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_rate_d = last_rate_q;
      last_pd_d   = last_pd_q;
      rate_prev_d = pipe.Rate;
      pd_prev_d   = pd_cur;
      // Changes seen outside IDLE are remembered so they are serviced once IDLE is reached.
      rate_pend_d = rate_pend_q | ((pipe.Rate != rate_prev_q) && (state_q != IDLE));
      pd_pend_d   = pd_pend_q | ((pd_cur != pd_prev_q) && (state_q != IDLE));
      op_done     = 1'b0;
      det_done    = 1'b0;

      case (state_q)
         RST_WAIT: begin
            if (cnt_q == RST_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         IDLE: begin
            cnt_d = '0;
            if (det_req && (pd_cur == PD_P1)) begin
               state_d = DETECT;
            end else if ((pipe.Rate != last_rate_q) || rate_pend_q) begin
               // Pending is consumed on entry so a change during the op re-arms it.
               state_d     = RATE;
               rate_pend_d = 1'b0;
            end else if ((pd_cur != last_pd_q) || pd_pend_q) begin
               state_d   = PWR;
               pd_pend_d = 1'b0;
            end
         end
         DETECT: begin
            if (cnt_q == DET_LAST) begin
               det_done = 1'b1;
               state_d  = RELEASE;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RATE: begin
            if (cnt_q == RATE_LAST) begin
               op_done     = 1'b1;
               last_rate_d = pipe.Rate;
               state_d     = IDLE;
               cnt_d       = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         PWR: begin
            if (cnt_q == PD_LAST) begin
               op_done   = 1'b1;
               last_pd_d = pd_cur;
               state_d   = IDLE;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RELEASE: begin
            if (!det_req) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = RST_WAIT;
            cnt_d   = '0;
         end
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < LANESNUMBER; gi++) begin : g_lane
         localparam int D = BASE_LATENCY + ((gi * SKEW_STEP) % (MAX_SKEW + 1));

         logic [W-1:0]  data_q [D];
         logic [W-1:0]  data_d [D];
         logic [KW-1:0] k_q [D];
         logic [KW-1:0] k_d [D];
         logic [D-1:0]  valid_q, valid_d;
         logic [D-1:0]  eidle_q, eidle_d;

         always_comb begin
            data_d[0]  = pipe.TxData[gi*W +: W];
            k_d[0]     = pipe.TxDataK[gi*KW +: KW];
            valid_d[0] = pipe.TxDataValid[gi];
            eidle_d[0] = pipe.TxElecIdle[gi];
            for (int s = 1; s < D; s++) begin
               data_d[s]  = data_q[s-1];
               k_d[s]     = k_q[s-1];
               valid_d[s] = valid_q[s-1];
               eidle_d[s] = eidle_q[s-1];
            end
         end

         always_ff @(posedge CLK or posedge reset) begin
            if (reset) begin
               for (int s = 0; s < D; s++) begin
                  data_q[s] <= '0;
                  k_q[s]    <= '0;
               end
               valid_q <= '0;
               eidle_q <= '1;
            end else begin
               data_q  <= data_d;
               k_q     <= k_d;
               valid_q <= valid_d;
               eidle_q <= eidle_d;
            end
         end

         // An absent far end looks like a permanently idle, silent line.
         assign rx_data[gi*W +: W]    = pipe.lane_present[gi] ? data_q[D-1] : '0;
         assign rx_datak[gi*KW +: KW] = pipe.lane_present[gi] ? k_q[D-1] : '0;
         assign rx_datavalid[gi]      = pipe.lane_present[gi] & valid_q[D-1];
         assign rx_valid[gi]          = pipe.lane_present[gi] & valid_q[D-1] & ~eidle_q[D-1];
         assign rx_eidle[gi]          = ~pipe.lane_present[gi] | eidle_q[D-1];
         assign rx_status[gi*3 +: 3]  =
            (det_done && pipe.lane_present[gi] && pipe.TxDetectRx_Loopback[gi]) ? 3'b011 : 3'b000;
      end

      if (LANESNUMBER > 1) begin : g_unused
         logic unused_pd;
         assign unused_pd = ^pipe.PowerDown[4*LANESNUMBER-1:4];
      end
   endgenerate

   assign pipe.RxData           = rx_data;
   assign pipe.RxDataK          = rx_datak;
   assign pipe.RxDataValid      = rx_datavalid;
   assign pipe.RxValid          = rx_valid;
   assign pipe.RxElectricalIdle = rx_eidle;
   assign pipe.RxStatus         = rx_status;
   assign pipe.PhyStatus        = ((state_q == RST_WAIT) || op_done || det_done) ? '1 : '0;
endmodule

// File: tb/tb_pipe_loopback_phy.sv
// Directed bench for pipe_loopback_phy: reset handshake, lane skew, electrical idle,
// receiver detect with presence mask, pending rate change, power change and reset abort.
module tb_pipe_loopback_phy;
   localparam int L = 16;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_assert = 0;
   int   n_fail = 0;
   int   pulses;

   always #5 clk = ~clk;

   pipe_loopback_phy_if #(.LANESNUMBER(L), .MAXPIPEWIDTH(W)) pif ();

   pipe_loopback_phy #(
      .LANESNUMBER(L), .MAXPIPEWIDTH(W), .BASE_LATENCY(2), .SKEW_STEP(1), .MAX_SKEW(3),
      .RESET_LATENCY(4), .DETECT_LATENCY(8), .RATE_LATENCY(16), .PD_LATENCY(4)
   ) dut (
      .CLK(clk),
      .reset(rst),
      .pipe(pif)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic count_pulses(input int n);
      pulses = 0;
      repeat (n) begin
         tick(1);
         if (pif.PhyStatus !== 16'h0000) pulses++;
      end
   endtask

   initial begin
      pif.TxData              = '0;
      pif.TxDataK             = '0;
      pif.TxDataValid         = '0;
      pif.TxElecIdle          = '1;
      pif.TxDetectRx_Loopback = '0;
      pif.PowerDown           = 64'h2222_2222_2222_2222;
      pif.Rate                = 4'd0;
      pif.lane_present        = 16'hFFFF;

      // Reset state and release handshake
      tick(2);
      chk("rst_phystatus", pif.PhyStatus, 16'hFFFF);
      chk("rst_rxstatus", pif.RxStatus, 48'h0);
      chk("rst_rxeidle", pif.RxElectricalIdle, 16'hFFFF);
      chk("rst_rxvalid", pif.RxValid, 16'h0000);
      rst = 1'b0;
      tick(3);
      chk("rel_phystatus_hi", pif.PhyStatus, 16'hFFFF);
      tick(1);
      chk("rel_phystatus_lo", pif.PhyStatus, 16'h0000);
      chk("rel_rxeidle", pif.RxElectricalIdle, 16'hFFFF);

      // Skew: lane delay 2,3,4,5 repeating every four lanes
      for (int i = 0; i < L; i++) pif.TxData[i*W +: W] = 32'hA5A5_0000 + i;
      pif.TxDataValid = '1;
      pif.TxElecIdle  = '0;
      tick(1);
      pif.TxData      = '0;
      pif.TxDataValid = '0;
      chk("skew_t1_dvalid", pif.RxDataValid, 16'h0000);
      tick(1);
      chk("skew_t2_dvalid", pif.RxDataValid, 16'h1111);
      chk("skew_t2_rxvalid", pif.RxValid, 16'h1111);
      chk("skew_t2_lane0", pif.RxData[0*W +: W], 32'hA5A5_0000);
      chk("skew_t2_lane4", pif.RxData[4*W +: W], 32'hA5A5_0004);
      chk("skew_t2_lane1", pif.RxData[1*W +: W], 32'h0);
      chk("skew_t2_eidle", pif.RxElectricalIdle, 16'hEEEE);
      tick(1);
      chk("skew_t3_dvalid", pif.RxDataValid, 16'h2222);
      chk("skew_t3_lane1", pif.RxData[1*W +: W], 32'hA5A5_0001);
      chk("skew_t3_lane0", pif.RxData[0*W +: W], 32'h0);
      tick(2);
      chk("skew_t5_dvalid", pif.RxDataValid, 16'h8888);
      chk("skew_t5_lane3", pif.RxData[3*W +: W], 32'hA5A5_0003);
      chk("skew_t5_eidle", pif.RxElectricalIdle, 16'h0000);

      // Valid data sent while electrically idle
      tick(1);
      pif.TxElecIdle  = '1;
      pif.TxDataValid = '1;
      tick(1);
      pif.TxElecIdle  = '0;
      pif.TxDataValid = '0;
      tick(1);
      chk("eidle_t2_dvalid", pif.RxDataValid, 16'h1111);
      chk("eidle_t2_rxvalid", pif.RxValid, 16'h0000);
      chk("eidle_t2_eidle", pif.RxElectricalIdle, 16'h1111);
      tick(3);
      chk("eidle_t5_dvalid", pif.RxDataValid, 16'h8888);
      chk("eidle_t5_rxvalid", pif.RxValid, 16'h0000);
      chk("eidle_t5_eidle", pif.RxElectricalIdle, 16'h8888);

      // Receiver detect on half-populated link, rate change arriving mid-detect
      tick(1);
      pif.lane_present        = 16'h00FF;
      pif.TxDetectRx_Loopback = 16'hFFFF;
      tick(3);
      pif.Rate = 4'd1;
      tick(4);
      chk("det_t7_phystatus", pif.PhyStatus, 16'h0000);
      tick(1);
      chk("det_t8_phystatus", pif.PhyStatus, 16'hFFFF);
      chk("det_t8_rxstatus", pif.RxStatus, 48'h0000_006D_B6DB);
      chk("det_t8_eidle", pif.RxElectricalIdle, 16'hFF00);
      tick(1);
      chk("det_t9_phystatus", pif.PhyStatus, 16'h0000);
      chk("det_t9_rxstatus", pif.RxStatus, 48'h0);
      count_pulses(10);
      chk("det_held_no_repulse", pulses, 0);
      pif.TxDetectRx_Loopback = '0;
      tick(16);
      chk("rate_t16_phystatus", pif.PhyStatus, 16'h0000);
      tick(1);
      chk("rate_t17_phystatus", pif.PhyStatus, 16'hFFFF);
      chk("rate_t17_rxstatus", pif.RxStatus, 48'h0);
      tick(1);
      chk("rate_t18_phystatus", pif.PhyStatus, 16'h0000);

      // Power state change P1 -> P0 on lane 0
      pif.lane_present = 16'hFFFF;
      pif.PowerDown    = 64'h2222_2222_2222_2220;
      tick(3);
      chk("pd_t3_phystatus", pif.PhyStatus, 16'h0000);
      tick(1);
      chk("pd_t4_phystatus", pif.PhyStatus, 16'hFFFF);
      count_pulses(6);
      chk("pd_single_pulse", pulses, 0);

      // Reset three cycles into a rate change aborts it
      pif.TxElecIdle = '0;
      pif.Rate       = 4'd2;
      tick(3);
      chk("abort_t3_phystatus", pif.PhyStatus, 16'h0000);
      chk("abort_pre_eidle", pif.RxElectricalIdle, 16'h0000);
      rst = 1'b1;
      #1;
      chk("abort_rst_phystatus", pif.PhyStatus, 16'hFFFF);
      chk("abort_rst_eidle", pif.RxElectricalIdle, 16'hFFFF);
      pif.Rate      = 4'd0;
      pif.PowerDown = 64'h2222_2222_2222_2222;
      tick(2);
      rst = 1'b0;
      tick(3);
      chk("abort_rel_hi", pif.PhyStatus, 16'hFFFF);
      tick(1);
      chk("abort_rel_lo", pif.PhyStatus, 16'h0000);
      count_pulses(25);
      chk("abort_no_rate_pulse", pulses, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/pipe_loopback_phy.md
# pipe_loopback_phy

Synthesizable, parametrised PIPE PHY loopback model for the PCIe controller bench and FPGA bring-up. It replaces the fixed zero-delay Tx→Rx wire loop and the hand-driven PhyStatus/RxStatus stimulus with a PHY-side responder. It provides per-lane configurable latency and skew, per-lane receiver presence, and PIPE-correct completion handshakes for reset, receiver detection, rate change and power-state change. It sits between the controller's PIPE Tx outputs and its PIPE Rx/status inputs.

## Interface
Parameters:
- LANESNUMBER, 16, number of PIPE lanes.
- MAXPIPEWIDTH, 32, data bits per lane; K bits per lane = MAXPIPEWIDTH/8.
- BASE_LATENCY, 2, minimum Tx→Rx delay in cycles (≥1).
- SKEW_STEP, 0, extra delay added per lane index.
- MAX_SKEW, 3, wrap limit for extra delay: lane i delay D_i = BASE_LATENCY + (i*SKEW_STEP) mod (MAX_SKEW+1).
- RESET_LATENCY, 4, cycles PhyStatus stays high after reset release.
- DETECT_LATENCY, 8, cycles from detect request to completion.
- RATE_LATENCY, 16, cycles from Rate change to completion.
- PD_LATENCY, 4, cycles from PowerDown change to completion.

Ports:
- CLK, in, 1, sole clock.
- reset, in, 1, asynchronous, active-high reset.
- TxData, in, MAXPIPEWIDTH*LANESNUMBER, transmit data.
- TxDataK, in, (MAXPIPEWIDTH/8)*LANESNUMBER, transmit K flags.
- TxDataValid, in, LANESNUMBER, transmit data valid.
- TxElecIdle, in, LANESNUMBER, transmit electrical idle.
- TxDetectRx_Loopback, in, LANESNUMBER, detect request (in P1).
- PowerDown, in, 4*LANESNUMBER, power state; lane 0 field is authoritative.
- Rate, in, 4, link rate.
- lane_present, in, LANESNUMBER, 1 = far-end receiver exists on lane.
- RxData, out, MAXPIPEWIDTH*LANESNUMBER, looped data.
- RxDataK, out, (MAXPIPEWIDTH/8)*LANESNUMBER, looped K flags.
- RxDataValid, out, LANESNUMBER, looped data valid.
- RxValid, out, LANESNUMBER, receiver symbol lock.
- RxElectricalIdle, out, LANESNUMBER, receive electrical idle.
- RxStatus, out, 3*LANESNUMBER, per-lane status.
- PhyStatus, out, LANESNUMBER, completion / PHY-not-ready.

## Operation
Datapath, per lane i:
- Shift register of depth D_i carries {data, K, valid, elecidle}.
- Stage reset values: data 0, K 0, valid 0, elecidle 1.
- If lane_present[i]=1:
  - RxData/RxDataK = delayed values.
  - RxDataValid = delayed valid.
  - RxValid = delayed valid & ~delayed elecidle.
  - RxElectricalIdle = delayed elecidle.
- If lane_present[i]=0: RxData/RxDataK/RxDataValid/RxValid = 0 and RxElectricalIdle = 1. lane_present is sampled combinationally at the output.

Control FSM (shared across lanes), states RST_WAIT, IDLE, DETECT, RATE, PWR, RELEASE:
- RST_WAIT: entered on reset. PhyStatus all ones. Counts RESET_LATENCY cycles, then PhyStatus goes all zeros → IDLE.
- IDLE, evaluated each cycle, priority detect > rate > powerdown:
  - Any TxDetectRx_Loopback bit set and PowerDown[3:0]==4'd2 (P1) → DETECT.
  - Rate ≠ last_rate, or rate_pend → RATE.
  - PowerDown[3:0] ≠ last_pd, or pd_pend → PWR.
- DETECT: count DETECT_LATENCY. On the final cycle, PhyStatus all ones for exactly 1 cycle. In that cycle RxStatus lane i = 3'b011 if lane_present[i] & TxDetectRx_Loopback[i], else 3'b000. Then → RELEASE.
- RELEASE: wait until TxDetectRx_Loopback == 0, then → IDLE. This prevents re-triggering on a held request.
- RATE: count RATE_LATENCY, then 1-cycle PhyStatus all-ones pulse. last_rate ← Rate, clear rate_pend → IDLE.
- PWR: same with PD_LATENCY. last_pd ← PowerDown[3:0], clear pd_pend.
- Rate or PowerDown changes while not in IDLE set rate_pend / pd_pend. Pending events are serviced in priority order after the current operation. No event is lost.
- RxStatus is 0 on every cycle except the detect completion cycle.

## Timing
- Reset (async assert):
  - PhyStatus all ones, RxStatus 0.
  - All shift stages cleared, so RxElectricalIdle all ones and RxValid/RxDataValid 0.
  - Counters and pend flags cleared; last_rate ← 0, last_pd ← 4'd2.
  - Reset mid-operation aborts that operation without emitting a completion pulse.
- Tx sampled at edge t appears on Rx after edge t+D_i-1, i.e. D_i edges of latency. Registered outputs.
- Operation latency: from the IDLE-sampling edge to the PhyStatus pulse is exactly N cycles (N = the op's latency parameter); the pulse is 1 cycle wide.
- Counters are $clog2(max latency)+1 bits wide. A latency parameter of 0 is illegal; the minimum is 1.

## Test plan
- Reset release → PhyStatus = 16'hFFFF for RESET_LATENCY=4 cycles, then 0. RxElectricalIdle = 16'hFFFF until Tx activity propagates.
- SKEW_STEP=1, MAX_SKEW=3, BASE=2: drive TxData 32'hA5A5_0000+i with valid=1 on every lane in one cycle. Data must appear on lane 0 after 2 cycles, lane 1 after 3, lane 3 after 5, lane 4 after 2.
- lane_present=16'h00FF, PowerDown=P1, TxDetectRx_Loopback=16'hFFFF → after 8 cycles a single-cycle PhyStatus=16'hFFFF with RxStatus lanes 0–7 = 3'b011 and lanes 8–15 = 0. No second pulse while the request is held.
- Rate changes 0→1 during DETECT → detect completes first; the rate pulse follows 16 cycles after returning to IDLE.
- TxElecIdle=1 with TxDataValid=1 → RxDataValid=1, RxValid=0, RxElectricalIdle=1 after D_i cycles.
- Assert reset 3 cycles into RATE → no completion pulse. RST_WAIT sequence restarts and last_rate = 0.
